// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID
// pipeline register, with a one-cycle bubble after reset and on every redirect.
module if_pc_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pc_plus4_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             branch_taken_i,
    input  logic             stall_i,
    input  logic [WIDTH-1:0] instr_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] ifid_pc_plus4_o,
    output logic [WIDTH-1:0] ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [WIDTH-1:0] fetch_cnt_o
);

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= WARMUP;
            pc_q            <= RESET_PC;
            ifid_pc_plus4_q <= '0;
            ifid_instr_q    <= '0;
            ifid_valid_q    <= 1'b0;
            fetch_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_cnt_q     <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_valid_d    = ifid_valid_q;
        fetch_cnt_d     = fetch_cnt_q;

        unique case (state_q)
            WARMUP: begin
                // All inputs ignored: the adders are still settling on RESET_PC.
                state_d         = RUN;
                pc_d            = RESET_PC;
                ifid_pc_plus4_d = '0;
                ifid_instr_d    = '0;
                ifid_valid_d    = 1'b0;
            end
            RUN: begin
                if (branch_taken_i) begin
                    // Redirect beats stall; the wrong-path fetch becomes a bubble.
                    pc_d            = {branch_target_i[WIDTH-1:2], 2'b00};
                    ifid_pc_plus4_d = '0;
                    ifid_instr_d    = '0;
                    ifid_valid_d    = 1'b0;
                end else if (!stall_i) begin
                    pc_d            = {pc_plus4_i[WIDTH-1:2], 2'b00};
                    ifid_pc_plus4_d = pc_plus4_i;
                    ifid_instr_d    = instr_i;
                    ifid_valid_d    = 1'b1;
                    fetch_cnt_d     = fetch_cnt_q + 1'b1;
                end
            end
            default: state_d = WARMUP;
        endcase
    end

    assign pc_o            = pc_q;
    assign ifid_pc_plus4_o = ifid_pc_plus4_q;
    assign ifid_instr_o    = ifid_instr_q;
    assign ifid_valid_o    = ifid_valid_q;
    assign fetch_cnt_o     = fetch_cnt_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed bench for if_pc_stage: a vector table for the run-mode sequence plus
// hand-written reset sequences; the bench models the PC+4 adder and instruction memory.
module tb_if_pc_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_plus4_i;
    logic [31:0] branch_target_i = '0;
    logic        branch_taken_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_pc_plus4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic [31:0] fetch_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    // Environment: PC+4 adder and a memory that returns address+1.
    assign pc_plus4_i = pc_o + 32'd4;
    assign instr_i    = pc_o + 32'd1;

    if_pc_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_plus4_i      (pc_plus4_i),
        .branch_target_i (branch_target_i),
        .branch_taken_i  (branch_taken_i),
        .stall_i         (stall_i),
        .instr_i         (instr_i),
        .pc_o            (pc_o),
        .ifid_pc_plus4_o (ifid_pc_plus4_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_valid_o    (ifid_valid_o),
        .fetch_cnt_o     (fetch_cnt_o)
    );

    typedef struct {
        logic        br;
        logic        st;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        v;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic br, input logic st, input logic [31:0] tgt,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] p4, input logic v, input logic [31:0] cnt);
        vec_t r;
        r.br = br; r.st = st; r.tgt = tgt; r.pc = pc;
        r.instr = instr; r.p4 = p4; r.v = v; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] p4, input logic v, input logic [31:0] cnt);
        check({tag, " pc"}, pc_o, pc);
        check({tag, " instr"}, ifid_instr_o, instr);
        check({tag, " pc_plus4"}, ifid_pc_plus4_o, p4);
        check({tag, " valid"}, {31'd0, ifid_valid_o}, {31'd0, v});
        check({tag, " cnt"}, fetch_cnt_o, cnt);
        $display("%s: pc=%h instr=%h p4=%h valid=%0b cnt=%0d",
                 tag, pc_o, ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o, fetch_cnt_o);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n;
        //               br    st    target        pc            instr         pc_plus4      v     cnt
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'd0); // warm-up
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,        32'h4,        32'h1,        32'h4,        1'b1, 32'd1);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,        32'h8,        32'h5,        32'h8,        1'b1, 32'd2);
        vecs[3]  = mk(1'b0, 1'b1, 32'h0,        32'h8,        32'h5,        32'h8,        1'b1, 32'd2);
        vecs[4]  = mk(1'b0, 1'b1, 32'h0,        32'h8,        32'h5,        32'h8,        1'b1, 32'd2);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,        32'hC,        32'h9,        32'hC,        1'b1, 32'd3);
        vecs[6]  = mk(1'b1, 1'b0, 32'h40,       32'h40,       32'h0,        32'h0,        1'b0, 32'd3);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,        32'h44,       32'h41,       32'h44,       1'b1, 32'd4);
        vecs[8]  = mk(1'b1, 1'b1, 32'h80,       32'h80,       32'h0,        32'h0,        1'b0, 32'd4);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,        32'h84,       32'h81,       32'h84,       1'b1, 32'd5);
        vecs[10] = mk(1'b1, 1'b0, 32'h107,      32'h104,      32'h0,        32'h0,        1'b0, 32'd5);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,        32'h108,      32'h105,      32'h108,      1'b1, 32'd6);
        vecs[12] = mk(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b0, 32'd6);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFD, 32'h0,        1'b1, 32'd7);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,        32'h4,        32'h1,        32'h4,        1'b1, 32'd8);

        // Reset held across a clock edge: nothing advances.
        #12;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        step();
        rst_i = 1'b0;

        for (int i = 0; i < 15; i++) begin
            branch_taken_i  = vecs[i].br;
            stall_i         = vecs[i].st;
            branch_target_i = vecs[i].tgt;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].p4,
                      vecs[i].v, vecs[i].cnt);
        end
        branch_taken_i = 1'b0;
        stall_i        = 1'b0;

        // Advance to pc=0x24 (bounded), then reset between edges.
        n = 0;
        while (pc_o != 32'h24 && n < 20) begin
            step();
            n++;
        end
        check("reach_0x24", pc_o, 32'h24);
        check("valid_before_rst", {31'd0, ifid_valid_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        #2;
        rst_i = 1'b0;

        // Warm-up must ignore a branch request.
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h200;
        step();
        check_all("warmup", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        branch_taken_i = 1'b0;
        step();
        check_all("post_warmup", 32'h4, 32'h1, 32'h4, 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
